sid_filter_mixer_mc: RTL and testbench
======================================

Name: sid_filter_mixer_mc

Overview:
Multi-voice successor to the single-channel SID filter: a time-multiplexed Chamberlin state-variable filter plus voice mixer and master volume.
- Accepts CHANNELS signed voice samples per sample strobe.
- Routes each voice either through the shared filter or around it.
- Applies LP/BP/HP mode select and master volume, then emits one saturated mono sample with a valid pulse.
- Sits between the voice generators and the audio DAC/PWM stage.
- Uses one shared multiplier, sequenced by an FSM.

Parameters:
- CHANNELS, 3, number of voice inputs (1..8).
- AUDIO_BDEPTH, 8, signed width of each voice input and of audio_out.
- FILTER_BDEPTH, 16, signed width of the lp/bp/hp state registers.
- FILTER_COEF_BDEPTH, 16, unsigned coefficient width.
- INPUT_GAIN_BITS, 6, left shift applied to voices entering the filter/mix domain.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sample_strobe, input, 1, one-cycle pulse; starts processing of one sample.
- audio_in, input, CHANNELS*AUDIO_BDEPTH, packed signed voices; channel i is at [i*AUDIO_BDEPTH +: AUDIO_BDEPTH].
- filt_route, input, CHANNELS, bit i=1 sends channel i into the filter, 0 bypasses it.
- f_coefficient, input, FILTER_COEF_BDEPTH, cutoff, unsigned Q0.16.
- q_coefficient, input, FILTER_COEF_BDEPTH, damping, unsigned Q4.12 (4096 = 1.0).
- en_lowpass, input, 1, add lp to the filtered mix.
- en_bandpass, input, 1, add bp to the filtered mix.
- en_highpass, input, 1, add hp to the filtered mix.
- volume, input, 5, master gain /16; values >16 clamp to 16.
- audio_out, output, AUDIO_BDEPTH, signed mixed sample.
- out_valid, output, 1, one-cycle pulse when audio_out updates.
- busy, output, 1, high from the cycle after an accepted strobe through the out_valid cycle.
- overrun, output, 1, sticky; set when a strobe arrives while busy.

Behaviour:
- Reset (async, rst_n=0): lp=bp=hp=0, audio_out=0, out_valid=0, busy=0, overrun=0, FSM=IDLE. Reset mid-sequence aborts with no out_valid; filter state is lost.
- On a strobe accepted at edge k, the block latches audio_in, filt_route, both coefficients, the three mode enables and volume. Later input changes do not affect that sample.
- FSM states and timing for a strobe at edge k (C = CHANNELS):
  - IDLE.
  - ACCUM, edges k+1..k+C: one channel per cycle. Voice is sign-extended and shifted left by INPUT_GAIN_BITS, then added to fin (routed) or byp (bypassed).
  - LP, k+C+1: lp += (f*bp)>>>16.
  - HP, k+C+2: hp = fin - lp - ((q*bp)>>>12).
  - BP, k+C+3: bp += (f*hp)>>>16.
  - MIX, k+C+4: mix = byp + sum of enabled lp/bp/hp.
  - OUT, k+C+5: audio_out = sat_AUDIO(((mix*vol)>>>4)>>>INPUT_GAIN_BITS), out_valid=1, busy=0, return to IDLE.
- Latency from strobe to out_valid is C+5 cycles (8 at default). Minimum strobe spacing is C+6 cycles.
- All shifts are arithmetic. Coefficients are zero-extended before the signed multiply.
- fin, lp, bp and hp saturate to the signed FILTER_BDEPTH range on every update, with no wrap-around.
- mix is computed at FILTER_BDEPTH+4 bits, unsaturated; the final output saturates to [-2^(AUDIO_BDEPTH-1), 2^(AUDIO_BDEPTH-1)-1].
- A strobe while busy is ignored and sets overrun. overrun is cleared only by reset. A strobe in the OUT cycle counts as busy.
- No modes enabled: the filter contributes 0 but its state still updates.
- volume 0 gives audio_out 0 with a normal out_valid.

Decomposition:
- Shared header sid_filter_defs.vh holds:
  - FSM state localparams.
  - Q-format shift constants: F_FRAC=16, Q_FRAC=12, VOL_UNITY=16.
  - A signed saturate function parametrised by width.
- Sub-module sid_svf_mac: acc ± (a*coef)>>>frac with saturation to FILTER_BDEPTH. It is instantiated once and shared across the LP/HP/BP states.

Test Plan:
1. Reset: hold rst_n=0 → audio_out=0, out_valid=0, busy=0, overrun=0. Deassert, apply no strobe → outputs stay 0.
2. Bypass: ch0=+50, others 0, filt_route=0, vol=16, one strobe → out_valid exactly 8 cycles later, audio_out=50, busy high for 8 cycles.
3. Lowpass step: route ch0 only, en_lowpass=1, f=8192, q=4096, ch0=+64 constant, vol=16, strobe every 20 cycles → audio_out within 64±1 after 200 samples, never above 80.
4. Highpass DC: same setup with only en_highpass → audio_out decays to |out|≤1 within 200 samples.
5. Saturation: three channels +127, unrouted, vol=16 → 127; three channels -128 → -128; vol=31 behaves as 16.
6. Overrun: second strobe 2 cycles after the first → ignored, single out_valid, overrun=1 and stays 1 until rst_n pulses low.

Source files
------------

// File: rtl/sid_filter_mixer_mc_pkg.sv
// Shared definitions for the multi-voice SID filter/mixer: FSM states,
// Q-format shift constants and a width-parametrised signed saturator.
package sid_filter_mixer_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_LP    = 3'd2,
        ST_HP    = 3'd3,
        ST_BP    = 3'd4,
        ST_MIX   = 3'd5,
        ST_OUT   = 3'd6
    } state_e;

    localparam int F_FRAC    = 16;
    localparam int Q_FRAC    = 12;
    localparam int VOL_UNITY = 16;
    localparam int VOL_SHIFT = $clog2(VOL_UNITY);

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int               width);
        logic signed [63:0] hi_v;
        logic signed [63:0] lo_v;
        logic signed [63:0] res_v;
        hi_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo_v = -(64'sd1 <<< (width - 1));
        if (value > hi_v) begin
            res_v = hi_v;
        end else if (value < lo_v) begin
            res_v = lo_v;
        end else begin
            res_v = value;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/sid_filter_mixer_mc_svf_mac.sv
// Shared multiply-accumulate for the state-variable filter:
// res = sat(acc +/- ((a * coef) >>> frac)), coef treated as unsigned.
module sid_filter_mixer_mc_svf_mac
    import sid_filter_mixer_mc_pkg::*;
#(
    parameter int FILTER_BDEPTH      = 16,
    parameter int FILTER_COEF_BDEPTH = 16,
    parameter int ACC_BDEPTH         = FILTER_BDEPTH + 2
) (
    input  logic signed [ACC_BDEPTH-1:0]         acc,
    input  logic signed [FILTER_BDEPTH-1:0]      a,
    input  logic        [FILTER_COEF_BDEPTH-1:0] coef,
    input  logic        [4:0]                    frac,
    input  logic                                 sub,
    output logic signed [FILTER_BDEPTH-1:0]      res
);

    localparam int PW = FILTER_BDEPTH + FILTER_COEF_BDEPTH + 1;

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] term_s;
    logic signed [63:0]   sum_s;

    // Single shared multiplier; the 64-bit sum cannot overflow before saturation.
    always_comb begin
        prod_s = PW'(a) * $signed(PW'({1'b0, coef}));
        term_s = prod_s >>> frac;
        if (sub) begin
            sum_s = 64'(acc) - 64'(term_s);
        end else begin
            sum_s = 64'(acc) + 64'(term_s);
        end
        res = FILTER_BDEPTH'(sat_signed(sum_s, FILTER_BDEPTH));
    end

endmodule

// File: rtl/sid_filter_mixer_mc.sv
// Time-multiplexed Chamberlin SVF plus voice mixer and master volume;
// one mono saturated sample per accepted strobe after CHANNELS+5 cycles.
module sid_filter_mixer_mc
    import sid_filter_mixer_mc_pkg::*;
#(
    parameter int CHANNELS           = 3,
    parameter int AUDIO_BDEPTH       = 8,
    parameter int FILTER_BDEPTH      = 16,
    parameter int FILTER_COEF_BDEPTH = 16,
    parameter int INPUT_GAIN_BITS    = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_strobe,
    input  logic [CHANNELS*AUDIO_BDEPTH-1:0] audio_in,
    input  logic [CHANNELS-1:0]              filt_route,
    input  logic [FILTER_COEF_BDEPTH-1:0]    f_coefficient,
    input  logic [FILTER_COEF_BDEPTH-1:0]    q_coefficient,
    input  logic                             en_lowpass,
    input  logic                             en_bandpass,
    input  logic                             en_highpass,
    input  logic [4:0]                       volume,
    output logic signed [AUDIO_BDEPTH-1:0]   audio_out,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int AB = AUDIO_BDEPTH;
    localparam int FB = FILTER_BDEPTH;
    localparam int CW = FILTER_COEF_BDEPTH;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MW = FB + 4;
    localparam int AW = FB + 2;
    localparam int OW = MW + 6;
    localparam logic signed [MW-1:0] MIX_ZERO = '0;

    state_e                   state_r;
    state_e                   state_s;
    logic                     busy_r;
    logic                     overrun_r;
    logic                     out_valid_r;
    logic signed [AB-1:0]     audio_out_r;
    logic [CHANNELS*AB-1:0]   voices_r;
    logic [CHANNELS-1:0]      route_r;
    logic [CW-1:0]            f_r;
    logic [CW-1:0]            q_r;
    logic                     en_lp_r;
    logic                     en_bp_r;
    logic                     en_hp_r;
    logic [4:0]               vol_r;
    logic [IW-1:0]            ch_r;
    logic signed [FB-1:0]     fin_r;
    logic signed [FB-1:0]     lp_r;
    logic signed [FB-1:0]     bp_r;
    logic signed [FB-1:0]     hp_r;
    logic signed [MW-1:0]     byp_r;
    logic signed [MW-1:0]     mix_r;

    logic                     accum_s;
    logic                     lp_ld_s;
    logic                     hp_ld_s;
    logic                     bp_ld_s;
    logic                     mix_ld_s;
    logic                     out_ld_s;
    logic signed [AW-1:0]     mac_acc_s;
    logic signed [FB-1:0]     mac_a_s;
    logic [CW-1:0]            mac_coef_s;
    logic [4:0]               mac_frac_s;
    logic                     mac_sub_s;
    logic signed [FB-1:0]     mac_res_s;

    logic signed [AB-1:0]     voice_s;
    logic signed [FB-1:0]     gain_s;
    logic signed [FB-1:0]     fin_next_s;
    logic signed [MW-1:0]     byp_next_s;
    logic signed [MW-1:0]     mix_s;
    logic signed [OW-1:0]     scaled_s;
    logic signed [AB-1:0]     out_s;

    // State register; busy mirrors "next state is not idle" so it is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Next-state sequencing: per-channel accumulate, then LP, HP, BP, mix, output.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (ch_r == IW'(CHANNELS - 1)) begin
                    state_s = ST_LP;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_LP:   state_s = ST_HP;
            ST_HP:   state_s = ST_BP;
            ST_BP:   state_s = ST_MIX;
            ST_MIX:  state_s = ST_OUT;
            ST_OUT:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes and operand steering for the shared MAC.
    always_comb begin
        accum_s    = 1'b0;
        lp_ld_s    = 1'b0;
        hp_ld_s    = 1'b0;
        bp_ld_s    = 1'b0;
        mix_ld_s   = 1'b0;
        out_ld_s   = 1'b0;
        mac_acc_s  = '0;
        mac_a_s    = '0;
        mac_coef_s = '0;
        mac_frac_s = 5'd0;
        mac_sub_s  = 1'b0;
        case (state_r)
            ST_ACCUM: accum_s = 1'b1;
            ST_LP: begin
                lp_ld_s    = 1'b1;
                mac_acc_s  = AW'(lp_r);
                mac_a_s    = bp_r;
                mac_coef_s = f_r;
                mac_frac_s = 5'(F_FRAC);
            end
            ST_HP: begin
                hp_ld_s    = 1'b1;
                mac_acc_s  = AW'(fin_r) - AW'(lp_r);
                mac_a_s    = bp_r;
                mac_coef_s = q_r;
                mac_frac_s = 5'(Q_FRAC);
                mac_sub_s  = 1'b1;
            end
            ST_BP: begin
                bp_ld_s    = 1'b1;
                mac_acc_s  = AW'(bp_r);
                mac_a_s    = hp_r;
                mac_coef_s = f_r;
                mac_frac_s = 5'(F_FRAC);
            end
            ST_MIX:  mix_ld_s = 1'b1;
            ST_OUT:  out_ld_s = 1'b1;
            default: accum_s  = 1'b0;
        endcase
    end

    sid_filter_mixer_mc_svf_mac #(
        .FILTER_BDEPTH      (FB),
        .FILTER_COEF_BDEPTH (CW),
        .ACC_BDEPTH         (AW)
    ) u_mac (
        .acc  (mac_acc_s),
        .a    (mac_a_s),
        .coef (mac_coef_s),
        .frac (mac_frac_s),
        .sub  (mac_sub_s),
        .res  (mac_res_s)
    );

    // Voice gain-up, mix sum and final volume/saturation arithmetic.
    always_comb begin
        voice_s    = $signed(voices_r[ch_r*AB +: AB]);
        gain_s     = FB'(voice_s) <<< INPUT_GAIN_BITS;
        fin_next_s = FB'(sat_signed(64'(fin_r) + 64'(gain_s), FB));
        byp_next_s = byp_r + MW'(gain_s);
        mix_s      = byp_r
                   + (en_lp_r ? MW'(lp_r) : MIX_ZERO)
                   + (en_bp_r ? MW'(bp_r) : MIX_ZERO)
                   + (en_hp_r ? MW'(hp_r) : MIX_ZERO);
        scaled_s   = OW'(mix_r) * $signed(OW'({1'b0, vol_r}));
        out_s      = AB'(sat_signed(64'((scaled_s >>> VOL_SHIFT) >>> INPUT_GAIN_BITS), AB));
    end

    // Input capture on an accepted strobe plus all datapath register updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voices_r    <= '0;
            route_r     <= '0;
            f_r         <= '0;
            q_r         <= '0;
            en_lp_r     <= 1'b0;
            en_bp_r     <= 1'b0;
            en_hp_r     <= 1'b0;
            vol_r       <= 5'd0;
            ch_r        <= '0;
            fin_r       <= '0;
            byp_r       <= '0;
            lp_r        <= '0;
            bp_r        <= '0;
            hp_r        <= '0;
            mix_r       <= '0;
            audio_out_r <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if ((state_r == ST_IDLE) && sample_strobe) begin
                voices_r <= audio_in;
                route_r  <= filt_route;
                f_r      <= f_coefficient;
                q_r      <= q_coefficient;
                en_lp_r  <= en_lowpass;
                en_bp_r  <= en_bandpass;
                en_hp_r  <= en_highpass;
                vol_r    <= (volume > 5'(VOL_UNITY)) ? 5'(VOL_UNITY) : volume;
                ch_r     <= '0;
                fin_r    <= '0;
                byp_r    <= '0;
            end
            if (accum_s) begin
                ch_r <= ch_r + IW'(1);
                if (route_r[ch_r]) begin
                    fin_r <= fin_next_s;
                end else begin
                    byp_r <= byp_next_s;
                end
            end
            if (lp_ld_s) begin
                lp_r <= mac_res_s;
            end
            if (hp_ld_s) begin
                hp_r <= mac_res_s;
            end
            if (bp_ld_s) begin
                bp_r <= mac_res_s;
            end
            if (mix_ld_s) begin
                mix_r <= mix_s;
            end
            if (out_ld_s) begin
                audio_out_r <= out_s;
                out_valid_r <= 1'b1;
            end
        end
    end

    // Sticky flag for strobes that arrive while a sample is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (sample_strobe && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign audio_out = audio_out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_sid_filter_mixer_mc.sv
// Scoreboard bench for sid_filter_mixer_mc: a behavioural filter model
// predicts each sample, a monitor compares whenever out_valid pulses.
module tb_sid_filter_mixer_mc;

    localparam int CH = 3;
    localparam int AB = 8;
    localparam int FB = 16;
    localparam int CW = 16;
    localparam int IG = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    sample_strobe;
    logic [CH*AB-1:0]        audio_in;
    logic [CH-1:0]           filt_route;
    logic [CW-1:0]           f_coefficient;
    logic [CW-1:0]           q_coefficient;
    logic                    en_lowpass;
    logic                    en_bandpass;
    logic                    en_highpass;
    logic [4:0]              volume;
    logic signed [AB-1:0]    audio_out;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;

    sid_filter_mixer_mc #(
        .CHANNELS           (CH),
        .AUDIO_BDEPTH       (AB),
        .FILTER_BDEPTH      (FB),
        .FILTER_COEF_BDEPTH (CW),
        .INPUT_GAIN_BITS    (IG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .audio_in      (audio_in),
        .filt_route    (filt_route),
        .f_coefficient (f_coefficient),
        .q_coefficient (q_coefficient),
        .en_lowpass    (en_lowpass),
        .en_bandpass   (en_bandpass),
        .en_highpass   (en_highpass),
        .volume        (volume),
        .audio_out     (audio_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int acc_cyc;
    } exp_t;

    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     valid_cnt = 0;
    int     last_out = 0;
    int     max_out = 0;
    longint m_lp = 0;
    longint m_bp = 0;
    longint m_hp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: the filter recurrences written directly as integer arithmetic.
    function automatic int model_sample(input logic [CH*AB-1:0] ain, input logic [CH-1:0] route,
                                        input longint f, input longint q,
                                        input bit elp, input bit ebp, input bit ehp,
                                        input int vol);
        longint fin = 0;
        longint byp = 0;
        longint mix;
        longint v;
        longint g;
        for (int i = 0; i < CH; i++) begin
            v = longint'($signed(ain[i*AB +: AB])) * (longint'(1) << IG);
            if (route[i]) fin = sat(fin + v, FB);
            else          byp = byp + v;
        end
        m_lp = sat(m_lp + ((f * m_bp) >>> 16), FB);
        m_hp = sat(fin - m_lp - ((q * m_bp) >>> 12), FB);
        m_bp = sat(m_bp + ((f * m_hp) >>> 16), FB);
        mix  = byp + (elp ? m_lp : 0) + (ebp ? m_bp : 0) + (ehp ? m_hp : 0);
        g    = (vol > 16) ? 16 : vol;
        return int'(sat(((mix * g) >>> 4) >>> IG, AB));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every out_valid pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            valid_cnt++;
            last_out = int'(audio_out);
            if (last_out > max_out) max_out = last_out;
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("audio_out", last_out, e.val);
                check("latency", cyc - e.acc_cyc, CH + 5);
            end
        end
    end

    task automatic do_strobe(input bit accept);
        exp_t e;
        @(negedge clk);
        sample_strobe = 1'b1;
        if (accept) begin
            e.val = model_sample(audio_in, filt_route, longint'(f_coefficient),
                                 longint'(q_coefficient), en_lowpass, en_bandpass,
                                 en_highpass, int'(volume));
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        m_lp = 0;
        m_bp = 0;
        m_hp = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_voices(input int c0, input int c1, input int c2);
        audio_in = {AB'(c2), AB'(c1), AB'(c0)};
    endtask

    task automatic set_filter(input logic [CH-1:0] r, input int f, input int q,
                              input bit lp, input bit bp, input bit hp, input int vol);
        filt_route    = r;
        f_coefficient = CW'(f);
        q_coefficient = CW'(q);
        en_lowpass    = lp;
        en_bandpass   = bp;
        en_highpass   = hp;
        volume        = 5'(vol);
    endtask

    initial begin
        int busy_cnt;
        int vc0;
        int gap;
        rst_n         = 1'b0;
        sample_strobe = 1'b0;
        set_voices(0, 0, 0);
        set_filter(3'b000, 0, 4096, 1'b0, 1'b0, 1'b0, 16);

        // Reset values, during and after reset with no strobe.
        repeat (3) @(negedge clk);
        check("rst_audio_out", audio_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_audio_out", audio_out, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_busy", busy, 0);

        // Bypass: latency and busy window.
        set_voices(50, 0, 0);
        set_filter(3'b000, 0, 4096, 1'b0, 1'b0, 1'b0, 16);
        do_strobe(1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("busy_cycles", busy_cnt, 8);
        check("busy_after_out", busy, 0);
        check("valid_at_latency", out_valid, 1);
        wait_drain();
        check("bypass_value", last_out, 50);

        // Saturation and volume clamping.
        set_voices(127, 127, 127);
        do_strobe(1'b1);
        wait_drain();
        check("sat_pos", last_out, 127);
        set_voices(-128, -128, -128);
        do_strobe(1'b1);
        wait_drain();
        check("sat_neg", last_out, -128);
        set_voices(50, 0, 0);
        volume = 5'd31;
        do_strobe(1'b1);
        wait_drain();
        check("vol_clamp", last_out, 50);
        volume = 5'd0;
        vc0 = valid_cnt;
        do_strobe(1'b1);
        wait_drain();
        check("vol_zero", last_out, 0);
        check("vol_zero_valid", valid_cnt - vc0, 1);
        check("no_overrun_yet", overrun, 0);

        // Lowpass step response.
        do_reset();
        set_voices(64, 0, 0);
        set_filter(3'b001, 8192, 4096, 1'b1, 1'b0, 1'b0, 16);
        max_out = -1000;
        for (int n = 0; n < 200; n++) begin
            do_strobe(1'b1);
            repeat (18) @(negedge clk);
        end
        wait_drain();
        check("lp_settled", (last_out >= 63 && last_out <= 65), 1);
        check("lp_peak_le_80", (max_out <= 80), 1);

        // Highpass on DC input decays toward zero.
        do_reset();
        set_filter(3'b001, 8192, 4096, 1'b0, 1'b0, 1'b1, 16);
        for (int n = 0; n < 200; n++) begin
            do_strobe(1'b1);
            repeat (18) @(negedge clk);
        end
        wait_drain();
        check("hp_decayed", (last_out >= -1 && last_out <= 1), 1);

        // Overrun: second strobe while busy is ignored, flag is sticky.
        do_reset();
        check("overrun_clear", overrun, 0);
        set_voices(50, 0, 0);
        set_filter(3'b000, 0, 4096, 1'b0, 1'b0, 1'b0, 16);
        vc0 = valid_cnt;
        do_strobe(1'b1);
        do_strobe(1'b0);
        wait_drain();
        repeat (12) @(negedge clk);
        check("overrun_single_valid", valid_cnt - vc0, 1);
        check("overrun_set", overrun, 1);
        do_strobe(1'b1);
        wait_drain();
        check("overrun_sticky", overrun, 1);
        do_reset();
        check("overrun_reset", overrun, 0);

        // Reset in mid-sequence aborts with no out_valid.
        vc0 = valid_cnt;
        do_strobe(1'b1);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (15) @(negedge clk);
        check("abort_no_valid", valid_cnt - vc0, 0);

        // Randomized traffic with inputs scrambled right after each strobe.
        vc0 = valid_cnt;
        for (int n = 0; n < 150; n++) begin
            audio_in = (CH*AB)'($urandom);
            set_filter(CH'($urandom), int'($urandom_range(0, 20000)),
                       int'($urandom_range(1024, 8192)), 1'($urandom), 1'($urandom),
                       1'($urandom), int'($urandom_range(0, 31)));
            do_strobe(1'b1);
            audio_in = (CH*AB)'($urandom);
            set_filter(CH'($urandom), int'($urandom), int'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), int'($urandom_range(0, 31)));
            gap = int'($urandom_range(CH + 4, CH + 12));
            repeat (gap) @(negedge clk);
        end
        wait_drain();
        check("rand_valid_count", valid_cnt - vc0, 150);
        check("rand_no_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
